// File: rtl/cac_dec_seq.sv
// Sequential Fibonacci-weight (FPF-CAC) codeword decoder: accumulates BPC
// weighted bits per cycle and flags forbidden 010/101 windows.
module cac_dec_seq #(
  parameter int unsigned CW  = 9,
  parameter int unsigned DW  = 7,
  parameter int unsigned BPC = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] codein,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] dataout,
  output logic          err
);

  localparam int unsigned NSTEP = (CW + BPC - 1) / BPC;
  localparam int unsigned SW    = $clog2(NSTEP + 1);

  // Fibonacci weights packed DW bits per index, truncated mod 2^DW.
  function automatic logic [CW*DW-1:0] weight_tab();
    logic [CW*DW-1:0] tab;
    int unsigned      a;
    int unsigned      b;
    int unsigned      t;
    tab = '0;
    a   = 1;
    b   = 1;
    for (int unsigned i = 0; i < CW; i++) begin
      tab[i*DW +: DW] = DW'(a);
      t = a + b;
      a = b;
      b = t;
    end
    return tab;
  endfunction

  localparam logic [CW*DW-1:0] WTAB = weight_tab();

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   code;
  logic [DW-1:0]   acc;
  logic [SW-1:0]   step;
  logic [DW-1:0]   win_sum;
  logic            err_c;

  // Weight sum of the code bits belonging to the current step's window.
  always_comb begin
    win_sum = '0;
    for (int unsigned i = 0; i < CW; i++) begin
      if (code[i] && (SW'(i / BPC) == step)) begin
        win_sum = win_sum + WTAB[i*DW +: DW];
      end
    end
  end

  // Forbidden-pattern detector on the incoming codeword, latched at capture.
  always_comb begin
    err_c = 1'b0;
    for (int unsigned i = 0; i + 2 < CW; i++) begin
      if ((codein[i +: 3] == 3'b010) || (codein[i +: 3] == 3'b101)) begin
        err_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      code      <= '0;
      acc       <= '0;
      step      <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            code     <= codein;
            acc      <= '0;
            step     <= '0;
            err      <= err_c;
            in_ready <= 1'b0;
            state    <= ACC;
          end
        end
        ACC: begin
          acc  <= acc + win_sum;
          step <= step + SW'(1);
          if (step == SW'(NSTEP - 1)) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign dataout = acc;

endmodule

// File: tb/tb_cac_dec_seq.sv
// Directed and randomized checks of cac_dec_seq for BPC=3, 1 and 9 against a
// sum-of-Fibonacci-weights / window-scan reference model.
module tb_cac_dec_seq;
  localparam int unsigned CW = 9;
  localparam int unsigned DW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [CW-1:0] codein;
  logic          ir   [3];
  logic          ov   [3];
  logic          er   [3];
  logic [DW-1:0] dout [3];

  int checks = 0;
  int errors = 0;
  int w [CW];
  int lat_exp [3] = '{3, 9, 1};

  cac_dec_seq #(.CW(9), .DW(7), .BPC(3)) u_b3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .codein(codein),
    .out_valid(ov[0]), .out_ready(out_ready), .dataout(dout[0]), .err(er[0]));
  cac_dec_seq #(.CW(9), .DW(7), .BPC(1)) u_b1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .codein(codein),
    .out_valid(ov[1]), .out_ready(out_ready), .dataout(dout[1]), .err(er[1]));
  cac_dec_seq #(.CW(9), .DW(7), .BPC(9)) u_b9 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .codein(codein),
    .out_valid(ov[2]), .out_ready(out_ready), .dataout(dout[2]), .err(er[2]));

  always #5 clk = ~clk;

  function automatic int ref_sum(input logic [CW-1:0] cw);
    int s = 0;
    for (int i = 0; i < CW; i++) if (cw[i]) s += w[i];
    return s % (1 << DW);
  endfunction

  function automatic int ref_err(input logic [CW-1:0] cw);
    for (int i = 0; i + 2 < CW; i++) begin
      if (cw[i +: 3] == 3'b010 || cw[i +: 3] == 3'b101) return 1;
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction on the BPC=3 instance; noise scrambles ignored inputs.
  task automatic xact(input logic [CW-1:0] cw, input int exp_d, input int exp_e,
                      input int hold, input bit noise);
    int lat = 0;
    chk("idle_in_ready", 32'(ir[0]), 32'd1);
    codein   = cw;
    in_valid = 1'b1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      in_valid  = noise ? 1'($urandom) : 1'b0;
      codein    = noise ? CW'($urandom) : cw;
      out_ready = noise ? 1'($urandom) : 1'b0;
      tick();
      if (ov[0]) begin
        lat = k;
        break;
      end
    end
    out_ready = 1'b0;
    chk("latency", 32'(lat), 32'd3);
    chk("dataout", 32'(dout[0]), 32'(exp_d));
    chk("err", 32'(er[0]), 32'(exp_e));
    chk("busy_in_ready", 32'(ir[0]), 32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = noise ? 1'($urandom) : 1'b0;
      codein   = noise ? CW'($urandom) : cw;
      tick();
      chk("hold_valid", 32'(ov[0]), 32'd1);
      chk("hold_data", 32'(dout[0]), 32'(exp_d));
      chk("hold_err", 32'(er[0]), 32'(exp_e));
      chk("hold_in_ready", 32'(ir[0]), 32'd0);
    end
    out_ready = 1'b1;
    in_valid  = noise ? 1'($urandom) : 1'b0;
    tick();
    chk("release_in_ready", 32'(ir[0]), 32'd1);
    chk("release_valid", 32'(ov[0]), 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    tick();
    chk("no_accept_on_release", 32'(ir[0]), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "simulation timeout");
  end

  initial begin
    int rise [3];
    logic [CW-1:0] cw;

    w[0] = 1;
    w[1] = 1;
    for (int i = 2; i < CW; i++) w[i] = w[i-1] + w[i-2];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; codein = '0;
    tick();
    tick();
    for (int n = 0; n < 3; n++) begin
      chk("rst_in_ready", 32'(ir[n]), 32'd1);
      chk("rst_out_valid", 32'(ov[n]), 32'd0);
      chk("rst_dataout", 32'(dout[n]), 32'd0);
      chk("rst_err", 32'(er[n]), 32'd0);
    end
    rst = 1'b0;

    xact(9'b000000001, 1, 0, 0, 1'b0);
    xact(9'b111111111, 88, 0, 0, 1'b0);
    xact(9'b110000000, 55, 0, 0, 1'b0);
    xact(9'b000000101, 3, 1, 0, 1'b0);
    xact(9'b000000010, 1, 1, 0, 1'b0);
    xact(9'b011011011, ref_sum(9'b011011011), ref_err(9'b011011011), 10, 1'b1);

    // Reset in the second ACC cycle drops the in-flight word.
    codein = 9'b000000101; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", 32'(ir[0]), 32'd1);
    chk("midrst_out_valid", 32'(ov[0]), 32'd0);
    chk("midrst_dataout", 32'(dout[0]), 32'd0);
    chk("midrst_err", 32'(er[0]), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("midrst_no_pulse", 32'(ov[0]), 32'd0);
    end
    xact(9'b000100000, 8, 1, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      cw = CW'($urandom);
      xact(cw, ref_sum(cw), ref_err(cw), int'($urandom_range(0, 4)), 1'b1);
    end

    // Exhaustive sweep across all three step widths in lockstep.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < (1 << CW); c++) begin
      cw = CW'(c);
      codein = cw;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int n = 0; n < 3; n++) rise[n] = 0;
      for (int k = 1; k <= 10; k++) begin
        tick();
        for (int n = 0; n < 3; n++) if (ov[n] && rise[n] == 0) rise[n] = k;
      end
      for (int n = 0; n < 3; n++) begin
        chk($sformatf("sweep_lat%0d_cw%0d", n, c), 32'(rise[n]), 32'(lat_exp[n]));
        chk($sformatf("sweep_data%0d_cw%0d", n, c), 32'(dout[n]), 32'(ref_sum(cw)));
        chk($sformatf("sweep_err%0d_cw%0d", n, c), 32'(er[n]), 32'(ref_err(cw)));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
